// File: rtl/sort_scheduler.sv
// Round-robin time-sharing of one systolic sort engine among NREQ requesters; pads batches to SIZE and drops pad zeros.
// Optional build macro SORT_SCHED_TIMEOUT_EN adds a WAIT/DRAIN cycle budget (TIMEOUT) that aborts a stuck batch.
module sort_scheduler #(
    parameter int SIZE    = 1024,
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 8192
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    output logic [NREQ-1:0]          grant,
    input  logic [NREQ*WIDTH-1:0]    in_data,
    input  logic [NREQ-1:0]          in_valid,
    input  logic [NREQ-1:0]          in_last,
    output logic [NREQ-1:0]          in_ready,
    output logic                     eng_rst_n,
    output logic [WIDTH-1:0]         eng_d,
    input  logic [WIDTH-1:0]         eng_q,
    input  logic                     eng_active_output,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(NREQ)-1:0]  out_id,
    output logic                     out_last,
    output logic                     done,
    output logic [1:0]               status
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(4*SIZE + TIMEOUT);

    localparam logic [CW-1:0]  SIZE_C     = CW'(SIZE);
    localparam logic [CW-1:0]  LAST_OC    = CW'(SIZE - 1);
    localparam logic [CW-1:0]  TWO_SIZE   = CW'(2*SIZE);
    localparam logic [CW-1:0]  LAST_SLOT  = CW'(2*SIZE - 1);
    localparam logic [CW-1:0]  LOAD_END   = CW'(2*SIZE + 1);
    localparam logic [IDW-1:0] LAST_ID    = IDW'(NREQ - 1);

    typedef enum logic [2:0] {S_IDLE, S_ENGRST, S_LOAD, S_WAIT, S_DRAIN, S_DONE} state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  id;
    logic [CW-1:0]   pc;
    logic [CW-1:0]   oc;
    logic [CW-1:0]   len;
    logic            batch_open;
    logic            underrun;
`ifdef SORT_SCHED_TIMEOUT_EN
    logic [CW-1:0]   tcnt;
`endif

    logic            found;
    logic [IDW-1:0]  sel;
    int              j;

    // First requester at or after the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[j]) begin
                found = 1'b1;
                sel   = IDW'(j);
            end
        end
    end

    logic [WIDTH-1:0] cur_data;
    logic             cur_valid;
    logic             cur_last;
    logic             fwd;

    assign cur_data  = in_data[id*WIDTH +: WIDTH];
    assign cur_valid = in_valid[id];
    assign cur_last  = in_last[id];
    // Pad zeros sort first, so the leading SIZE-len outputs are exactly the padding.
    assign fwd       = eng_active_output && (oc >= (SIZE_C - len));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ptr        <= '0;
            id         <= '0;
            pc         <= '0;
            oc         <= '0;
            len        <= '0;
            batch_open <= 1'b0;
            underrun   <= 1'b0;
            grant      <= '0;
            in_ready   <= '0;
            eng_rst_n  <= 1'b0;
            eng_d      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_id     <= '0;
            out_last   <= 1'b0;
            done       <= 1'b0;
            status     <= 2'b00;
`ifdef SORT_SCHED_TIMEOUT_EN
            tcnt       <= '0;
`endif
        end else begin
            in_ready  <= '0;
            done      <= 1'b0;
            status    <= 2'b00;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
            case (state)
                S_IDLE: begin
                    eng_rst_n <= 1'b1;
                    eng_d     <= '0;
                    if (found) begin
                        id        <= sel;
                        grant     <= NREQ'(1) << sel;
                        eng_rst_n <= 1'b0;
                        state     <= S_ENGRST;
                    end
                end
                S_ENGRST: begin
                    eng_rst_n  <= 1'b1;
                    pc         <= '0;
                    len        <= '0;
                    batch_open <= 1'b1;
                    underrun   <= 1'b0;
                    state      <= S_LOAD;
                end
                S_LOAD: begin
                    pc <= pc + 1'b1;
                    if (!pc[0]) begin
                        if (batch_open && pc < TWO_SIZE) in_ready[id] <= 1'b1;
                    end else begin
                        // Odd phase: the strobe closes here; the taken word is held for the next two cycles.
                        eng_d <= '0;
                        if (in_ready[id]) begin
                            if (cur_valid) begin
                                eng_d <= cur_data;
                                len   <= len + 1'b1;
                                if (cur_last || pc == LAST_SLOT) batch_open <= 1'b0;
                            end else begin
                                batch_open <= 1'b0;
                                underrun   <= 1'b1;
                            end
                        end
                        if (pc == LOAD_END) begin
                            state <= S_WAIT;
                            oc    <= '0;
`ifdef SORT_SCHED_TIMEOUT_EN
                            tcnt  <= '0;
`endif
                        end
                    end
                end
                S_WAIT, S_DRAIN: begin
                    eng_d <= '0;
                    if (eng_active_output) begin
                        state <= S_DRAIN;
                        oc    <= oc + 1'b1;
                        if (fwd) begin
                            out_valid <= 1'b1;
                            out_data  <= eng_q;
                            out_id    <= id;
                            out_last  <= (oc == LAST_OC);
                        end
                        if (oc == LAST_OC) begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            status <= {1'b0, underrun};
                        end
                    end
`ifdef SORT_SCHED_TIMEOUT_EN
                    tcnt <= tcnt + 1'b1;
                    if (tcnt == CW'(TIMEOUT - 1) && !(eng_active_output && oc == LAST_OC)) begin
                        state     <= S_DONE;
                        done      <= 1'b1;
                        status    <= {1'b1, underrun};
                        eng_rst_n <= 1'b0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
`endif
                end
                S_DONE: begin
                    grant     <= '0;
                    eng_rst_n <= 1'b1;
                    ptr       <= (id == LAST_ID) ? '0 : id + 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
